// File: rtl/fib_sched_pkg.sv
// Shared types, seed constants and the round-robin pick helper for the
// Fibonacci job scheduler.
package fib_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RESP = 2'd2
    } state_e;

    // Engine seed: term0 = term1 = 1, so prev and sum both start at 1.
    localparam int SEED_PREV = 1;
    localparam int SEED_SUM  = 1;

    // Upper bound on requesters the pick helper can search.
    localparam int MAX_REQ = 32;

    // Returns the first asserted valid bit found searching upward from ptr
    // with wrap over n entries, or -1 when nothing is asserted. The loop runs
    // from the far end down so the closest hit to ptr is written last.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                   input int ptr,
                                   input int n);
        int idx;
        rr_pick = -1;
        for (int off = MAX_REQ - 1; off >= 0; off--) begin
            if (off < n) begin
                idx = ptr + off;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[4:0]]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/fib_step_engine.sv
// Fibonacci step datapath: holds prev/sum and their sticky overflow flags.
// prev carries the current term, sum the next one.
module fib_step_engine
    import fib_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    output logic [DATA_WIDTH-1:0] term,
    output logic                  ovf
);

    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  prev_ovf_q;
    logic                  sum_ovf_q;
    logic [DATA_WIDTH:0]   add_d;

    // One extra bit on the adder; its carry only feeds the overflow flag.
    assign add_d = {1'b0, sum_q} + {1'b0, prev_q};

    // Seed on load, advance one term per step, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            sum_q      <= '0;
            prev_ovf_q <= 1'b0;
            sum_ovf_q  <= 1'b0;
        end else if (load) begin
            prev_q     <= DATA_WIDTH'(SEED_PREV);
            sum_q      <= DATA_WIDTH'(SEED_SUM);
            prev_ovf_q <= 1'b0;
            sum_ovf_q  <= 1'b0;
        end else if (step) begin
            prev_q     <= sum_q;
            sum_q      <= add_d[DATA_WIDTH-1:0];
            prev_ovf_q <= sum_ovf_q;
            sum_ovf_q  <= sum_ovf_q | prev_ovf_q | add_d[DATA_WIDTH];
        end
    end

    assign term = prev_q;
    assign ovf  = prev_ovf_q;

endmodule

// File: rtl/fib_nth_scheduler.sv
// Round-robin scheduler sharing one Fibonacci step engine among NUM_REQ
// requesters; one job in flight at a time.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; requesters hold req_valid/req_index until granted, and the
// response stays stable while rsp_valid is high and rsp_ready is low.
module fib_nth_scheduler
    import fib_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 6,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*IDX_WIDTH-1:0] req_index,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_overflow,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    state_e              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     id_q;
    logic [IDX_WIDTH-1:0] cnt_q;
    logic                rsp_valid_q;

    int                  pick_w;
    logic [ID_W-1:0]     pick_idx;
    logic                grant_any;
    logic [IDX_WIDTH-1:0] k_w;
    logic [ID_W-1:0]     ptr_d;
    logic                hs;

    // Arbiter: grant the round-robin winner while idle; never during reset.
    always_comb begin
        pick_w    = rr_pick(MAX_REQ'(req_valid), int'(ptr_q), NUM_REQ);
        grant_any = (state_q == IDLE) && !reset && (pick_w >= 0);
        pick_idx  = ID_W'(pick_w);
        req_ready = '0;
        if (grant_any) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    assign k_w   = req_index[pick_idx*IDX_WIDTH +: IDX_WIDTH];
    assign hs    = |(req_valid & req_ready);
    assign ptr_d = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    // Job FSM: accept a grant, count k engine steps, hold the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        id_q  <= pick_idx;
                        cnt_q <= k_w;
                        ptr_q <= ptr_d;
                        if (k_w != '0) begin
                            state_q <= STEP;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == IDX_WIDTH'(1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    fib_step_engine #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_engine (
        .clk   (clk),
        .reset (reset),
        .load  (hs),
        .step  (state_q == STEP),
        .term  (rsp_data),
        .ovf   (rsp_overflow)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_nth_scheduler.sv
// Directed bench for fib_nth_scheduler: a 32-bit and an 8-bit instance share
// all inputs so wide and narrow overflow behaviour is checked on the same jobs.
module tb_fib_nth_scheduler;

  localparam int NR  = 4;
  localparam int IW  = 6;

  logic           clk;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR*IW-1:0] req_index;
  logic           rsp_ready;

  logic [NR-1:0]  req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_data;
  logic           rsp_overflow;
  logic           busy;
  logic [1:0]     dbg_state;

  logic [NR-1:0]  req_ready8;
  logic           rsp_valid8;
  logic [1:0]     rsp_id8;
  logic [7:0]     rsp_data8;
  logic           rsp_overflow8;
  logic           busy8;
  logic [1:0]     dbg_state8;

  int checks;
  int failures;
  logic [1:0] exp_q[$];

  fib_nth_scheduler #(.DATA_WIDTH(32), .NUM_REQ(NR), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
    .busy(busy), .dbg_state(dbg_state)
  );

  fib_nth_scheduler #(.DATA_WIDTH(8), .NUM_REQ(NR), .IDX_WIDTH(IW)) dut8 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready8), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id8), .rsp_data(rsp_data8), .rsp_overflow(rsp_overflow8),
    .busy(busy8), .dbg_state(dbg_state8)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one job from requester id and check latency, response and return to idle.
  task automatic do_job(input int id, input int k,
                        input logic [31:0] ed, input logic eo,
                        input logic [7:0] ed8, input logic eo8);
    int cyc;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_index[id*IW +: IW] = IW'(k);
    #1;
    cyc = 0;
    while (!req_ready[id] && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("grant_seen", {63'd0, req_ready[id]}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_latency", 64'(cyc), 64'(k + 1));
    check("rsp_data", 64'(rsp_data), 64'(ed));
    check("rsp_overflow", 64'(rsp_overflow), 64'(eo));
    check("rsp_id", 64'(rsp_id), 64'(id));
    check("rsp_data8", 64'(rsp_data8), 64'(ed8));
    check("rsp_overflow8", 64'(rsp_overflow8), 64'(eo8));
    @(negedge clk);
    check("idle_after_accept", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    int          id;
    int          k;
    logic [31:0] d32;
    logic        o32;
    logic [7:0]  d8;
    logic        o8;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc;
    int grants;
    int gidx;
    int order[5];
    logic [31:0] hold_data;
    logic [1:0]  hold_id;
    logic        seen;

    vecs[0] = '{2, 10, 32'd89,         1'b0, 8'd89,  1'b0};
    vecs[1] = '{0,  0, 32'd1,          1'b0, 8'd1,   1'b0};
    vecs[2] = '{1,  1, 32'd1,          1'b0, 8'd1,   1'b0};
    vecs[3] = '{3,  2, 32'd2,          1'b0, 8'd2,   1'b0};
    vecs[4] = '{0, 12, 32'd233,        1'b0, 8'd233, 1'b0};
    vecs[5] = '{1, 13, 32'd377,        1'b0, 8'd121, 1'b1};
    vecs[6] = '{2, 46, 32'd2971215073, 1'b0, 8'd225, 1'b1};
    vecs[7] = '{3, 47, 32'd512559680,  1'b1, 8'd64,  1'b1};
    vecs[8] = '{1,  7, 32'd21,         1'b0, 8'd21,  1'b0};
    vecs[9] = '{0,  3, 32'd3,          1'b0, 8'd3,   1'b0};

    checks = 0;
    failures = 0;
    reset = 1'b1;
    req_valid = '0;
    req_index = '0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(rsp_id), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_rsp_overflow", 64'(rsp_overflow), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    // Table-driven single jobs
    for (int i = 0; i < 10; i++) begin
      do_job(vecs[i].id, vecs[i].k, vecs[i].d32, vecs[i].o32, vecs[i].d8, vecs[i].o8);
    end

    // Contention: all valid from reset, k=3 each; grants 0,1,2,3,0
    @(negedge clk);
    reset = 1'b1;
    req_valid = 4'hF;
    req_index = {6'd3, 6'd3, 6'd3, 6'd3};
    #1;
    check("req_ready_forced_in_reset", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    order = '{0, 1, 2, 3, 0};
    grants = 0;
    cyc = 0;
    while ((grants < 5 || exp_q.size() > 0) && cyc < 300) begin
      #1;
      if (req_ready != '0) begin
        check("grant_onehot", 64'($countones(req_ready)), 64'd1);
        gidx = 0;
        for (int j = 0; j < NR; j++) if (req_ready[j]) gidx = j;
        if (grants < 5) begin
          check("grant_order", 64'(gidx), 64'(order[grants]));
          exp_q.push_back(2'(gidx));
          grants++;
          if (grants == 5) begin
            @(posedge clk);
            req_valid = '0;
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() > 0) begin
          check("contention_rsp_id", 64'(rsp_id), 64'(exp_q.pop_front()));
          check("contention_rsp_data", 64'(rsp_data), 64'd3);
        end else begin
          check("unexpected_rsp", 64'd1, 64'(exp_q.size()));
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("contention_done", 64'(grants), 64'd5);
    repeat (6) @(negedge clk);

    // Skip: ptr now 1; requesters 1,2,3 valid, 2 drops during job of 1 -> next grant 3
    req_valid = 4'b1110;
    #1;
    check("skip_first_grant", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid = 4'b1000;
    cyc = 0;
    #1;
    while (req_ready == '0 && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("skip_second_grant", 64'(req_ready), 64'b1000);
    @(negedge clk);
    req_valid = '0;
    repeat (8) @(negedge clk);

    // Backpressure: requester 3 k=4 -> 5, requester 0 waits with k=2
    rsp_ready = 1'b0;
    req_index[3*IW +: IW] = 6'd4;
    req_index[0 +: IW] = 6'd2;
    req_valid = 4'b1000;
    #1;
    check("bp_grant3", 64'(req_ready), 64'b1000);
    @(negedge clk);
    req_valid = 4'b0001;
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    hold_data = rsp_data;
    hold_id = rsp_id;
    check("bp_data", 64'(rsp_data), 64'd5);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(rsp_valid), 64'd1);
      check("bp_data_stable", 64'(rsp_data), 64'(hold_data));
      check("bp_id_stable", 64'(rsp_id), 64'(hold_id));
      check("bp_no_grant", 64'(req_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_idle_after_accept", 64'(busy), 64'd0);
    check("bp_rsp_valid_low", 64'(rsp_valid), 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_second_data", 64'(rsp_data), 64'd2);
    check("bp_second_id", 64'(rsp_id), 64'd0);
    repeat (3) @(negedge clk);

    // Reset mid-job: requester 2 k=20, then reset during STEP
    req_index[2*IW +: IW] = 6'd20;
    req_valid = 4'b0100;
    #1;
    check("rst_job_grant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    check("rst_job_in_step", 64'(dbg_state), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_mid_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_mid_rsp_overflow", 64'(rsp_overflow), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_no_stale_rsp", 64'(seen), 64'd0);
    // ptr back at 0: with 1 and 3 waiting, 1 wins
    req_index[1*IW +: IW] = 6'd5;
    req_index[3*IW +: IW] = 6'd1;
    req_valid = 4'b1010;
    #1;
    check("rst_ptr_zero", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid = '0;
    cyc = 1;
    while (!rsp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("post_rst_latency", 64'(cyc), 64'd6);
    check("post_rst_data", 64'(rsp_data), 64'd8);
    check("post_rst_id", 64'(rsp_id), 64'd1);
    repeat (3) @(negedge clk);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
